vga_pixel_addr_gen: RTL

//  Parametrised VGA raster timing and source-image address generator. Generates hsync/vsync and the display window.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/scaled_axis_counter.sv | 74 +++++++
 rtl/vga_pixel_addr_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Default raster timing for the VGA pixel address generator.
//            The defaults describe 640x480 timing clocked 4x faster than the
//            pixel clock, with a 128x96 source image upscaled 20x horizontally
//            and 5x vertically.
// Contents : Timing localparams and a width helper.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int C_H_TOTAL  = 3200;
  localparam int C_H_SYNC   = 384;
  localparam int C_H_BP     = 192;
  localparam int C_H_SCALE  = 20;
  localparam int C_IMG_W    = 128;
  localparam int C_V_TOTAL  = 521;
  localparam int C_V_SYNC   = 2;
  localparam int C_V_BP     = 29;
  localparam int C_V_SCALE  = 5;
  localparam int C_IMG_H    = 96;
  localparam int C_SYNC_POL = 0;

  // Bit width needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scaled_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : scaled_axis_counter
// Purpose  : One axis of the upscaler. A prescaler counts SCALE steps per
//            source coordinate; the coordinate runs 0..LEN-1. Both are held at
//            zero while the axis window is closed.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            step_i              - one step of the raw axis counter
//            window_active_i     - window state of the position being stepped to
//            coord_o             - registered source coordinate
//            advance_o           - this step moves coord_o to the next value
// Revision : 1.0 - initial release
// ============================================================================
module scaled_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SCALE = 1,
  parameter int LEN   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         step_i,
  input  logic                         window_active_i,
  output logic [clog2_min1(LEN)-1:0]   coord_o,
  output logic                         advance_o
);

  localparam int DW = clog2_min1(SCALE);
  localparam int CW = clog2_min1(LEN);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCALE - 1);
  localparam logic [CW-1:0] COORD_LAST = CW'(LEN - 1);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] coord_q, coord_d;
  logic          win_q, win_d;

  always_comb begin
    div_d     = div_q;
    coord_d   = coord_q;
    win_d     = win_q;
    advance_o = 1'b0;
    if (step_i) begin
      win_d = window_active_i;
      // Entering the window always starts at coordinate 0, prescaler 0;
      // win_q distinguishes entry from the last prescale step (SCALE=1).
      if (!window_active_i || !win_q) begin
        div_d   = '0;
        coord_d = '0;
      end else if (div_q == DIV_LAST) begin
        div_d     = '0;
        advance_o = 1'b1;
        coord_d   = (coord_q == COORD_LAST) ? '0 : coord_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      coord_q <= '0;
      win_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      coord_q <= coord_d;
      win_q   <= win_d;
    end
  end

  assign coord_o = coord_q;

endmodule
`default_nettype wire

// File: rtl/vga_pixel_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_addr_gen
// Purpose  : VGA raster timing plus source-image address generation for an
//            upscaled image read from a synchronous ROM/RAM.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            en_i                - count enable; low freezes everything
//            hsync_o, vsync_o    - syncs, active level set by SYNC_POL
//            h_count_o, v_count_o- raw raster counters
//            display_en_o        - inside both display windows
//            pixel_x_o, pixel_y_o- source column / row
//            pixel_addr_o        - pixel_y*IMG_W + pixel_x
//            line_end_o          - h_count == H_TOTAL-1
//            frame_start_o       - h_count == 0 and v_count == 0
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_addr_gen
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL  = C_H_TOTAL,
  parameter int H_SYNC   = C_H_SYNC,
  parameter int H_BP     = C_H_BP,
  parameter int H_SCALE  = C_H_SCALE,
  parameter int IMG_W    = C_IMG_W,
  parameter int V_TOTAL  = C_V_TOTAL,
  parameter int V_SYNC   = C_V_SYNC,
  parameter int V_BP     = C_V_BP,
  parameter int V_SCALE  = C_V_SCALE,
  parameter int IMG_H    = C_IMG_H,
  parameter int SYNC_POL = C_SYNC_POL
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en_i,
  output logic                                   hsync_o,
  output logic                                   vsync_o,
  output logic [clog2_min1(H_TOTAL)-1:0]         h_count_o,
  output logic [clog2_min1(V_TOTAL)-1:0]         v_count_o,
  output logic                                   display_en_o,
  output logic [clog2_min1(IMG_W)-1:0]           pixel_x_o,
  output logic [clog2_min1(IMG_H)-1:0]           pixel_y_o,
  output logic [clog2_min1(IMG_W*IMG_H)-1:0]     pixel_addr_o,
  output logic                                   line_end_o,
  output logic                                   frame_start_o
);

  localparam int HW = clog2_min1(H_TOTAL);
  localparam int VW = clog2_min1(V_TOTAL);
  localparam int AW = clog2_min1(IMG_W * IMG_H);

  localparam int H_DISP_START = H_SYNC + H_BP;
  localparam int H_DISP_END   = H_DISP_START + IMG_W * H_SCALE;
  localparam int V_DISP_START = V_SYNC + V_BP;
  localparam int V_DISP_END   = V_DISP_START + IMG_H * V_SCALE;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
  localparam logic          SYNC_ACT = (SYNC_POL != 0);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          disp_q, disp_d;
  logic          line_end_q, line_end_d;
  logic          frame_start_q, frame_start_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_h_win_d;
  logic          w_v_win_d;
  logic          w_h_adv;
  logic          w_v_adv;

  // Every registered output is derived from the next counter values so that
  // all outputs describe the same raster position as h_count/v_count.
  always_comb begin
    w_h_wrap = (h_q == H_LAST);
    w_v_wrap = (v_q == V_LAST);
    h_d      = w_h_wrap ? '0 : h_q + 1'b1;
    v_d      = v_q;
    if (w_h_wrap) begin
      v_d = w_v_wrap ? '0 : v_q + 1'b1;
    end

    w_h_win_d = (int'(h_d) >= H_DISP_START) && (int'(h_d) < H_DISP_END);
    w_v_win_d = (int'(v_d) >= V_DISP_START) && (int'(v_d) < V_DISP_END);
    disp_d    = w_h_win_d && w_v_win_d;

    hsync_d       = (int'(h_d) < H_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    vsync_d       = (int'(v_d) < V_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    line_end_d    = (h_d == H_LAST);
    frame_start_d = (h_d == '0) && (v_d == '0);
  end

  // Row base only moves on line boundaries, when the V axis advances.
  always_comb begin
    row_base_d = row_base_q;
    if (!w_v_win_d) begin
      row_base_d = '0;
    end else if (w_v_adv) begin
      row_base_d = row_base_q + ROW_STEP;
    end

    addr_d = addr_q;
    if (!disp_d) begin
      addr_d = '0;
    end else if (!disp_q) begin
      addr_d = row_base_d;
    end else if (w_h_adv) begin
      addr_d = addr_q + 1'b1;
    end
  end

  // Horizontal axis is gated by the full display window so pixel_x stays 0
  // during vertical blanking as well.
  scaled_axis_counter #(
    .SCALE (H_SCALE),
    .LEN   (IMG_W)
  ) u_h_axis (
    .clk             (clk),
    .rst_n           (rst_n),
    .step_i          (en_i),
    .window_active_i (disp_d),
    .coord_o         (pixel_x_o),
    .advance_o       (w_h_adv)
  );

  scaled_axis_counter #(
    .SCALE (V_SCALE),
    .LEN   (IMG_H)
  ) u_v_axis (
    .clk             (clk),
    .rst_n           (rst_n),
    .step_i          (en_i && w_h_wrap),
    .window_active_i (w_v_win_d),
    .coord_o         (pixel_y_o),
    .advance_o       (w_v_adv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      disp_q        <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
      row_base_q    <= '0;
      addr_q        <= '0;
    end else if (en_i) begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      disp_q        <= disp_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
      row_base_q    <= row_base_d;
      addr_q        <= addr_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign h_count_o     = h_q;
  assign v_count_o     = v_q;
  assign display_en_o  = disp_q;
  assign pixel_addr_o  = addr_q;
  assign line_end_o    = line_end_q;
  assign frame_start_o = frame_start_q;

endmodule
`default_nettype wire
